serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that computes a WIDTH-bit difference A − B by sequencing a single one-bit full-subtractor cell over WIDTH clock cycles, LSB first. It sits between a requester that issues a start/operand pair and the one-bit subtractor datapath. It owns operand capture, borrow chaining, bit counting, result assembly and the start/done handshake. It trades latency for area compared with a ripple array.

---
 rtl/serial_sub_ctrl_pkg.sv | 18 +
 rtl/serial_sub_ctrl_fs_cell.sv | 18 +
 rtl/serial_sub_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
//   - State encoding for the controller FSM.
//   - Default operand width.
package serial_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_SHIFT = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    SHIFT = ENC_SHIFT,
    DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// One-bit full subtractor, purely combinational.
// Ports:
//   ai, bi  operand bits (minuend, subtrahend)
//   bin     borrow in
//   d       difference bit
//   bout    borrow out
module fs_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ai ^ bi ^ bin;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: computes a - b over WIDTH cycles,
// LSB first, using a single fs_cell.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, a, b       request and operands (sampled only in IDLE)
//   busy              high while bits are being processed
//   done              one-cycle pulse when results are final
//   diff              a - b mod 2^WIDTH
//   borrow_out        1 iff a < b (unsigned)
//   ovf               two's complement overflow of a - b
//
// state | meaning
// IDLE  | waiting for start; results held
// SHIFT | one bit processed per cycle
// DONE  | results final, done pulse
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             sa;
  logic             sb;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_step;

  fs_cell u_cell (
    .ai   (a_sh[0]),
    .bi   (b_sh[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done decode straight from the state register, so they carry no
  // combinational dependence on the inputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= 1'b0;
      cnt  <= '0;
      sa   <= a[WIDTH-1];
      sb   <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      brw  <= cell_bout;
      // difference bits enter at the MSB and walk down, so the first bit
      // computed ends in bit 0 after WIDTH steps
      diff <= {cell_d, diff[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (last_step) begin
        borrow_out <= cell_bout;
        ovf        <= (sa ^ sb) & (sa ^ cell_d);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf;

  bit clk_run = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_log[$];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {ovf, borrow, diff} from plain integer arithmetic
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    logic [W-1:0] dd;
    logic bo, ov;
    dd = W'(int'(x) - int'(y));
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    bo = (x < y);
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return {ov, bo, dd};
  endfunction

  // Model: an op accepted at edge E0 finishes at E0+W; the next request can be
  // taken no earlier than E0+W+2.
  bit           m_acc = 1'b0;
  int           m_acc_cyc = 0;
  logic [W+1:0] m_pend = '0;
  logic [W-1:0] e_diff = '0;
  logic         e_bo = 1'b0;
  logic         e_ov = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc  = 1'b0;
      e_diff = '0;
      e_bo   = 1'b0;
      e_ov   = 1'b0;
    end else begin
      cyc++;
      if (m_acc && cyc == m_acc_cyc + W) begin
        e_diff = m_pend[W-1:0];
        e_bo   = m_pend[W];
        e_ov   = m_pend[W+1];
      end
      if ((!m_acc || cyc >= m_acc_cyc + W + 2) && start) begin
        m_acc     = 1'b1;
        m_acc_cyc = cyc;
        m_pend    = ref_sub(a, b);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic eb, ed;
    if (rst_n) begin
      eb = m_acc && cyc >= m_acc_cyc && cyc < m_acc_cyc + W;
      ed = m_acc && cyc == m_acc_cyc + W;
      chk("busy", busy, eb);
      chk("done", done, ed);
      if (!eb) begin
        chk("diff", diff, e_diff);
        chk("borrow_out", borrow_out, e_bo);
        chk("ovf", ovf, e_ov);
      end
      if (busy) busy_cnt++;
      if (done) done_log.push_back(cyc);
    end
  end

  task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y, output int e0);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string name, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_diff"}, diff, 0);
    chk({name, "_borrow"}, borrow_out, 0);
    chk({name, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, at, at2, nd;

    #2 rst_n = 1'b0;
    #3 chk_zero("reset");
    #2 rst_n = 1'b1;

    chk("model_basic", ref_sub(8'd100, 8'd37), {2'b00, 8'h3F});
    chk("model_under", ref_sub(8'h00, 8'h01), {2'b01, 8'hFF});
    chk("model_ovf", ref_sub(8'h80, 8'h01), {2'b10, 8'h7F});
    chk("model_proto", ref_sub(8'hF0, 8'h0F), {2'b00, 8'hE1});
    chk("model_abort", ref_sub(8'h55, 8'h2A), {2'b00, 8'h2B});

    #3 clk_run = 1'b1;
    repeat (2) @(negedge clk);

    // basic
    busy_cnt = 0;
    pulse_start(8'd100, 8'd37, e0);
    wait_done("basic", at);
    chk("basic_latency", at - e0, W);
    chk("basic_diff", diff, 8'h3F);
    chk("basic_borrow", borrow_out, 0);
    chk("basic_ovf", ovf, 0);
    chk("basic_busy_cycles", busy_cnt, W);
    repeat (2) @(negedge clk);

    // underflow, then hold a few idle cycles
    pulse_start(8'h00, 8'h01, e0);
    wait_done("under", at);
    chk("under_diff", diff, 8'hFF);
    chk("under_borrow", borrow_out, 1);
    chk("under_ovf", ovf, 0);
    repeat (3) @(negedge clk);
    chk("under_hold_diff", diff, 8'hFF);

    // reset with the clock stopped
    @(negedge clk);
    clk_run = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_zero("stopped_reset");
    #3 rst_n = 1'b1;
    #2 clk_run = 1'b1;
    repeat (2) @(negedge clk);

    // signed overflow
    pulse_start(8'h80, 8'h01, e0);
    wait_done("ovf", at);
    chk("ovf_diff", diff, 8'h7F);
    chk("ovf_borrow", borrow_out, 0);
    chk("ovf_ovf", ovf, 1);
    repeat (2) @(negedge clk);

    // protocol: start held high, operands changed mid-operation
    @(negedge clk);
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    repeat (3) @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    wait_done("proto1", at);
    chk("proto1_latency", at - e0, W);
    chk("proto1_diff", diff, 8'hE1);
    chk("proto1_borrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    chk("proto2_accept_busy", busy, 1);
    start = 1'b0;
    wait_done("proto2", at2);
    chk("proto2_done_edge", at2 - e0, 2 * W + 2);
    chk("proto2_diff", diff, 8'hFF);
    chk("proto2_borrow", borrow_out, 1);
    repeat (2) @(negedge clk);

    // mid-operation reset after three bit steps
    pulse_start(8'h55, 8'h2A, e0);
    repeat (3) @(negedge clk);
    nd = done_log.size();
    #1 rst_n = 1'b0;
    #1 chk_zero("abort_reset");
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_log.size() - nd, 0);
    pulse_start(8'h55, 8'h2A, e0);
    wait_done("restart", at);
    chk("restart_latency", at - e0, W);
    chk("restart_diff", diff, 8'h2B);
    chk("restart_borrow", borrow_out, 0);
    chk("restart_ovf", ovf, 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
